// File: rtl/key_pkg.sv
// Shared HID keycodes and chord FSM state encoding for the keyboard front end.
package key_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_K    = 8'h0E;
  localparam logic [7:0] KEY_L    = 8'h0F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    LOCK
  } chord_state_t;

endpackage

// File: rtl/key_hold_counter.sv
// Per-key saturating count of frames a key has been held; restarts at 0 on
// every fresh press so a new hold never inherits a stale count.
module key_hold_counter #(
  parameter int HOLD_W = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_en,
  input  logic              match,
  input  logic              held,
  output logic [HOLD_W-1:0] count
);

  localparam logic [HOLD_W-1:0] CNT_MAX = '1;

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // A press edge is match with held still low, so it clears like a release
  always_comb begin
    cnt_d = cnt_q;
    if (!match || !held) begin
      cnt_d = '0;
    end else if (frame_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/key_event_tracker.sv
// Keyboard front end: matches configured keycodes against USB slots and
// produces held levels, press/release pulses, hold counts and a two-key chord.
module key_event_tracker
  import key_pkg::*;
#(
  parameter int                     NUM_SLOTS    = 4,
  parameter int                     NUM_KEYS     = 4,
  parameter logic [NUM_KEYS*8-1:0]  KEY_CODES    = {KEY_L, KEY_K, KEY_S, KEY_A},
  parameter int                     HOLD_W       = 6,
  parameter int                     CHORD_A      = 0,
  parameter int                     CHORD_B      = 1,
  parameter int                     CHORD_WINDOW = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_en,
  input  logic [NUM_SLOTS*8-1:0]     keycode,
  output logic [NUM_KEYS-1:0]        key_held,
  output logic [NUM_KEYS-1:0]        key_press,
  output logic [NUM_KEYS-1:0]        key_release,
  output logic [NUM_KEYS*HOLD_W-1:0] hold_frames,
  output logic                       chord
);

  localparam int               WIN_W       = $clog2(CHORD_WINDOW + 2);
  localparam logic [WIN_W-1:0] WIN_LIMIT   = WIN_W'(CHORD_WINDOW);
  localparam logic [WIN_W-1:0] WIN_TIMEOUT = WIN_W'(CHORD_WINDOW + 1);

  if ((CHORD_A == CHORD_B) || (CHORD_A < 0) || (CHORD_B < 0) ||
      (CHORD_A >= NUM_KEYS) || (CHORD_B >= NUM_KEYS)) begin : g_bad_chord
    $error("key_event_tracker: CHORD_A/CHORD_B must be distinct valid key indices");
  end

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] key_held_q, key_held_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  chord_state_t        state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [WIN_W-1:0]    win_inc;
  logic                chord_q, chord_d;
  logic                press_a, press_b, held_a, held_b;

  // An unused (8'h00) key code must never match an empty slot
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if ((KEY_CODES[8*i +: 8] != KEY_NONE) &&
            (keycode[8*s +: 8] == KEY_CODES[8*i +: 8])) begin
          match[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    key_held_d    = match;
    key_press_d   = match & ~key_held_q;
    key_release_d = ~match & key_held_q;
  end

  assign press_a = key_press_q[CHORD_A];
  assign press_b = key_press_q[CHORD_B];
  assign held_a  = key_held_q[CHORD_A];
  assign held_b  = key_held_q[CHORD_B];
  assign win_inc = win_q + WIN_W'(frame_en);

  // Chord detector works off registered pulses, so a chord lags its press by one cycle
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    chord_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_a && press_b) begin
          chord_d = 1'b1;
          state_d = LOCK;
        end else if (press_a) begin
          state_d = WAIT_B;
          win_d   = '0;
        end else if (press_b) begin
          state_d = WAIT_A;
          win_d   = '0;
        end
      end
      WAIT_B: begin
        if (press_b && (win_q <= WIN_LIMIT)) begin
          chord_d = 1'b1;
          state_d = LOCK;
        end else if (!held_a || (win_inc == WIN_TIMEOUT)) begin
          state_d = IDLE;
          win_d   = '0;
        end else begin
          win_d = win_inc;
        end
      end
      WAIT_A: begin
        if (press_a && (win_q <= WIN_LIMIT)) begin
          chord_d = 1'b1;
          state_d = LOCK;
        end else if (!held_b || (win_inc == WIN_TIMEOUT)) begin
          state_d = IDLE;
          win_d   = '0;
        end else begin
          win_d = win_inc;
        end
      end
      LOCK: begin
        if (!held_a && !held_b) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        win_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_held_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      state_q       <= IDLE;
      win_q         <= '0;
      chord_q       <= 1'b0;
    end else begin
      key_held_q    <= key_held_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      state_q       <= state_d;
      win_q         <= win_d;
      chord_q       <= chord_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_hold
    key_hold_counter #(
      .HOLD_W(HOLD_W)
    ) u_hold (
      .Clk      (Clk),
      .Reset    (Reset),
      .frame_en (frame_en),
      .match    (match[i]),
      .held     (key_held_q[i]),
      .count    (hold_frames[i*HOLD_W +: HOLD_W])
    );
  end

  assign key_held    = key_held_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign chord       = chord_q;

endmodule

// File: tb/tb_key_event_tracker.sv
// Self-checking bench for key_event_tracker: directed scenarios plus random
// keycode traffic compared every cycle against a behavioural model.
module tb_key_event_tracker;

  localparam int NUM_SLOTS    = 4;
  localparam int NUM_KEYS     = 4;
  localparam int HOLD_W       = 6;
  localparam int CHORD_A      = 0;
  localparam int CHORD_B      = 1;
  localparam int CHORD_WINDOW = 2;
  localparam int HOLD_MAX     = (1 << HOLD_W) - 1;

  localparam int M_IDLE    = 0;
  localparam int M_PENDING = 1;
  localparam int M_LOCK    = 2;

  logic                       Clk = 1'b0;
  logic                       Reset;
  logic                       frame_en;
  logic [NUM_SLOTS*8-1:0]     keycode;
  logic [NUM_KEYS-1:0]        key_held;
  logic [NUM_KEYS-1:0]        key_press;
  logic [NUM_KEYS-1:0]        key_release;
  logic [NUM_KEYS*HOLD_W-1:0] hold_frames;
  logic                       chord;

  int errors = 0;
  int checks = 0;
  int chord_count = 0;

  int codes [NUM_KEYS] = '{8'h04, 8'h16, 8'h0E, 8'h0F};

  logic [NUM_KEYS-1:0] m_held, m_press, m_release;
  int                  m_hold [NUM_KEYS];
  logic                m_chord;
  int                  m_mode;
  int                  m_pend_key;
  int                  m_waited;

  always #5 Clk = ~Clk;

  key_event_tracker #(
    .NUM_SLOTS    (NUM_SLOTS),
    .NUM_KEYS     (NUM_KEYS),
    .KEY_CODES    (32'h0F0E1604),
    .HOLD_W       (HOLD_W),
    .CHORD_A      (CHORD_A),
    .CHORD_B      (CHORD_B),
    .CHORD_WINDOW (CHORD_WINDOW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_en    (frame_en),
    .keycode     (keycode),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .hold_frames (hold_frames),
    .chord       (chord)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic key_in_slots(input logic [NUM_SLOTS*8-1:0] kc, input int k);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (codes[k] != 0 && int'(kc[8*s +: 8]) == codes[k]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Reference model: one pending "first key" plus frames waited since its press
  task automatic model_step();
    logic [NUM_KEYS-1:0] now_down, was_held, was_pressed;
    int partner;
    was_held    = m_held;
    was_pressed = m_press;
    if (Reset) begin
      m_held = '0; m_press = '0; m_release = '0; m_chord = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) m_hold[k] = 0;
      m_mode = M_IDLE; m_waited = 0; m_pend_key = 0;
      return;
    end
    for (int k = 0; k < NUM_KEYS; k++) now_down[k] = key_in_slots(keycode, k);
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!now_down[k] || !was_held[k]) m_hold[k] = 0;
      else if (frame_en && m_hold[k] < HOLD_MAX) m_hold[k] = m_hold[k] + 1;
    end
    m_press   = now_down & ~was_held;
    m_release = ~now_down & was_held;
    m_held    = now_down;
    m_chord   = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (was_pressed[CHORD_A] && was_pressed[CHORD_B]) begin
          m_chord = 1'b1; m_mode = M_LOCK;
        end else if (was_pressed[CHORD_A] || was_pressed[CHORD_B]) begin
          m_mode = M_PENDING; m_waited = 0;
          m_pend_key = was_pressed[CHORD_A] ? CHORD_A : CHORD_B;
        end
      end
      M_PENDING: begin
        partner = (m_pend_key == CHORD_A) ? CHORD_B : CHORD_A;
        if (was_pressed[partner] && m_waited <= CHORD_WINDOW) begin
          m_chord = 1'b1; m_mode = M_LOCK;
        end else if (!was_held[m_pend_key]) begin
          m_mode = M_IDLE;
        end else begin
          if (frame_en) m_waited++;
          if (m_waited > CHORD_WINDOW) m_mode = M_IDLE;
        end
      end
      default: begin
        if (!was_held[CHORD_A] && !was_held[CHORD_B]) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [NUM_KEYS*HOLD_W-1:0] exp_hold;
    for (int k = 0; k < NUM_KEYS; k++) exp_hold[k*HOLD_W +: HOLD_W] = HOLD_W'(m_hold[k]);
    checkOutput("held", key_held, m_held);
    checkOutput("press", key_press, m_press);
    checkOutput("release", key_release, m_release);
    checkOutput("hold_frames", hold_frames, exp_hold);
    checkOutput("chord", chord, m_chord);
  endtask

  task automatic applyStimulus(input logic rst, input logic fe, input logic [NUM_SLOTS*8-1:0] kc);
    Reset    = rst;
    frame_en = fe;
    keycode  = kc;
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
    if (chord === 1'b1) chord_count++;
  endtask

  initial begin
    logic [NUM_SLOTS*8-1:0] kc;
    logic [7:0] pick;
    Reset = 1'b1; frame_en = 1'b0; keycode = '0;
    m_held = '0; m_press = '0; m_release = '0; m_chord = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) m_hold[k] = 0;
    m_mode = M_IDLE; m_pend_key = 0; m_waited = 0;

    $display("[TB] reset and single key A");
    applyStimulus(1, 0, '0);
    applyStimulus(1, 1, 32'h00000004);
    checkOutput("reset_dominates_held", key_held, 0);
    applyStimulus(0, 0, 32'h00000004);
    checkOutput("a_press", key_press, 4'b0001);
    checkOutput("a_held", key_held, 4'b0001);
    applyStimulus(0, 0, 32'h00000004);
    checkOutput("a_press_one_cycle", key_press, 4'b0000);
    applyStimulus(0, 0, '0);
    checkOutput("a_release", key_release, 4'b0001);
    applyStimulus(0, 0, '0);
    checkOutput("a_release_one_cycle", key_release, 4'b0000);

    $display("[TB] duplicate slots and toggling");
    applyStimulus(0, 0, 32'h04040404);
    checkOutput("dup_press", key_press, 4'b0001);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(0, 0, (j % 2 == 0) ? 32'h0000000E : 32'h0);
      if (j % 2 == 0) checkOutput("toggle_press", key_press, 4'b0100);
      else            checkOutput("toggle_release", key_release, 4'b0100);
    end
    applyStimulus(0, 0, '0);

    $display("[TB] hold K across 70 frames");
    applyStimulus(0, 1, 32'h0E000000);
    checkOutput("k_hold_start", hold_frames[2*HOLD_W +: HOLD_W], 0);
    for (int f = 1; f <= 70; f++) begin
      applyStimulus(0, 1, 32'h0E000000);
      checkOutput("k_hold_count", hold_frames[2*HOLD_W +: HOLD_W], (f < HOLD_MAX) ? f : HOLD_MAX);
      applyStimulus(0, 0, 32'h0E000000);
    end
    applyStimulus(0, 0, '0);
    checkOutput("k_hold_cleared", hold_frames[2*HOLD_W +: HOLD_W], 0);

    $display("[TB] simultaneous chord");
    applyStimulus(0, 0, 32'h04160000);
    checkOutput("sim_held", key_held, 4'b0011);
    applyStimulus(0, 0, 32'h04160000);
    checkOutput("sim_chord", chord, 1);
    chord_count = 0;
    for (int f = 0; f < 10; f++) begin
      applyStimulus(0, 1, 32'h04160000);
      applyStimulus(0, 0, 32'h04160000);
    end
    checkOutput("sim_single_chord", chord_count, 0);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, '0);

    $display("[TB] chord inside window");
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 1, 32'h00000004);
    applyStimulus(0, 1, 32'h00000004);
    applyStimulus(0, 0, 32'h00001604);
    applyStimulus(0, 0, 32'h00001604);
    checkOutput("window_chord", chord, 1);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, '0);

    $display("[TB] chord window expired");
    chord_count = 0;
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 0, 32'h00000004);
    for (int f = 0; f < 3; f++) applyStimulus(0, 1, 32'h00000004);
    for (int f = 0; f < 10; f++) applyStimulus(0, f % 2, 32'h00001604);
    checkOutput("timeout_no_chord", chord_count, 0);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, '0);

    $display("[TB] release before window, then reversed order");
    chord_count = 0;
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, '0);
    applyStimulus(0, 0, 32'h00000016);
    applyStimulus(0, 0, 32'h00000016);
    applyStimulus(0, 0, 32'h00001604);
    checkOutput("release_no_chord", chord_count, 0);
    applyStimulus(0, 0, 32'h00001604);
    checkOutput("wait_a_chord", chord, 1);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, '0);

    $display("[TB] reset while waiting for B");
    applyStimulus(0, 0, 32'h00000004);
    applyStimulus(0, 1, 32'h00000004);
    applyStimulus(1, 1, 32'h00000004);
    checkOutput("rst_mid_held", key_held, 0);
    checkOutput("rst_mid_hold", hold_frames, 0);
    applyStimulus(0, 0, 32'h00000004);
    checkOutput("rst_fresh_press", key_press, 4'b0001);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, '0);

    $display("[TB] random traffic");
    kc = '0;
    for (int n = 0; n < 500; n++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if ($urandom_range(3) == 0) begin
          case ($urandom_range(7))
            0, 1:    pick = 8'h00;
            2, 6:    pick = 8'h04;
            3, 7:    pick = 8'h16;
            4:       pick = 8'h0E;
            default: pick = ($urandom_range(1) == 0) ? 8'h0F : 8'($urandom_range(255));
          endcase
          kc[8*s +: 8] = pick;
        end
      end
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(2) == 0), kc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
